// File: rtl/rgb_pwm_pkg.sv
// Shared widths, channel slice positions and duty type for the RGB PWM driver.
package rgb_pwm_pkg;
  localparam int CH_W  = 8;
  localparam int RGB_W = 24;
  localparam int R_HI  = 23;
  localparam int R_LO  = 16;
  localparam int G_HI  = 15;
  localparam int G_LO  = 8;
  localparam int B_HI  = 7;
  localparam int B_LO  = 0;

  typedef logic [CH_W-1:0] duty_t;
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: compares the shared period counter against this channel's
// active duty and registers the result.
module pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  duty_t cnt,
  input  duty_t duty,
  output logic  pwm
);

  logic pwm_q, pwm_d;

  // 0xFF must be fully on, which a plain cnt < duty compare cannot reach.
  always_comb begin
    pwm_d = (cnt < duty) | (duty == 8'hFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= pwm_d;
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB PWM driver: colours are staged on load and swapped into the
// active duty only at a period boundary so no period is ever torn.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] rgb,
  input  logic             load,
  output logic             pending,
  output logic             frame_start,
  output logic             pwm_r,
  output logic             pwm_g,
  output logic             pwm_b
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  duty_t            cnt_q, cnt_d;
  logic [RGB_W-1:0] staged_q, staged_d;
  logic [RGB_W-1:0] duty_q, duty_d;
  logic             pending_q, pending_d;
  logic             fs_q;
  logic             tick, wrap;

  assign tick = (pre_q == PRE_MAX);
  assign wrap = tick & (cnt_q == 8'hFF);

  always_comb begin
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d     = tick ? cnt_q + 8'd1 : cnt_q;
    staged_d  = load ? rgb : staged_q;
    pending_d = pending_q | load;
    duty_d    = duty_q;
    // A load landing on the wrap cycle bypasses staging so it is not lost.
    if (wrap) begin
      pending_d = 1'b0;
      if (load)           duty_d = rgb;
      else if (pending_q) duty_d = staged_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      staged_q  <= '0;
      duty_q    <= '0;
      pending_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      staged_q  <= staged_d;
      duty_q    <= duty_d;
      pending_q <= pending_d;
      fs_q      <= wrap;
    end
  end

  pwm_channel u_r (.clk(clk), .rst_n(rst_n), .cnt(cnt_q), .duty(duty_q[R_HI:R_LO]), .pwm(pwm_r));
  pwm_channel u_g (.clk(clk), .rst_n(rst_n), .cnt(cnt_q), .duty(duty_q[G_HI:G_LO]), .pwm(pwm_g));
  pwm_channel u_b (.clk(clk), .rst_n(rst_n), .cnt(cnt_q), .duty(duty_q[B_HI:B_LO]), .pwm(pwm_b));

  assign pending     = pending_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: a PRESCALE=1 and a PRESCALE=4 instance share stimulus
// and are checked every clock against a time-based reference model.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] rgb;
  logic        load;
  logic [1:0]  pend, fs;
  logic [2:0]  pw0, pw4;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rgb(rgb), .load(load),
    .pending(pend[0]), .frame_start(fs[0]),
    .pwm_r(pw0[0]), .pwm_g(pw0[1]), .pwm_b(pw0[2])
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rgb(rgb), .load(load),
    .pending(pend[1]), .frame_start(fs[1]),
    .pwm_r(pw4[0]), .pwm_g(pw4[1]), .pwm_b(pw4[2])
  );

  // Reference model: index 0 is PRESCALE=1, index 1 is PRESCALE=4.
  int unsigned t [2];
  logic [23:0] m_staged [2];
  logic [23:0] m_duty [2];
  bit          m_pend [2];
  bit          e_fs [2];
  bit [2:0]    e_pwm [2];

  int tests = 0;
  int fails = 0;
  int hi [2][3];
  int fsn [2];

  function automatic int unsigned pscale(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        t[k] = 0; m_staged[k] = '0; m_duty[k] = '0; m_pend[k] = 0;
        e_fs[k] = 0; e_pwm[k] = '0;
      end else begin
        int unsigned p, cnt;
        bit wrap;
        logic [7:0] d;
        p    = pscale(k);
        cnt  = (t[k] / p) % 256;
        wrap = (t[k] % (256 * p)) == (256 * p - 1);
        for (int c = 0; c < 3; c++) begin
          d = m_duty[k][8*(2-c) +: 8];
          e_pwm[k][c] = (cnt < d) || (d == 8'hFF);
        end
        e_fs[k] = wrap;
        if (wrap) begin
          if (load)         m_duty[k] = rgb;
          else if (m_pend[k]) m_duty[k] = m_staged[k];
          m_pend[k] = 0;
        end else if (load) begin
          m_pend[k] = 1;
        end
        if (load) m_staged[k] = rgb;
        t[k] = t[k] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pending_p1", int'(pend[0]), int'(m_pend[0]));
    chk("pending_p4", int'(pend[1]), int'(m_pend[1]));
    chk("frame_start_p1", int'(fs[0]), int'(e_fs[0]));
    chk("frame_start_p4", int'(fs[1]), int'(e_fs[1]));
    chk("pwm_p1", int'(pw0), int'(e_pwm[0]));
    chk("pwm_p4", int'(pw4), int'(e_pwm[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    for (int c = 0; c < 3; c++) begin
      hi[0][c] += int'(pw0[c]);
      hi[1][c] += int'(pw4[c]);
    end
    fsn[0] += int'(fs[0]);
    fsn[1] += int'(fs[1]);
  endtask

  task automatic measure(input int n);
    for (int k = 0; k < 2; k++) begin
      fsn[k] = 0;
      for (int c = 0; c < 3; c++) hi[k][c] = 0;
    end
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_edge();
    #1;
    check_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic goto_wrap1();
    while (t[0] % 256 != 255) step();
  endtask

  task automatic goto_wrap4();
    while (t[1] % 1024 != 1023) step();
  endtask

  task automatic load_one(input logic [23:0] v);
    rgb  = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  logic [23:0] sweep [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                             24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

  initial begin
    rgb = '0; load = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset mid-run, then idle
    load_one(24'hABCDEF);
    repeat (37) step();
    do_reset();
    chk("rst_pwm_p1", int'(pw0), 0);
    chk("rst_pending_p1", int'(pend[0]), 0);
    measure(512);
    chk("idle_fs_count_p1", fsn[0], 2);
    chk("idle_fs_count_p4", fsn[1], 0);
    for (int c = 0; c < 3; c++) chk("idle_hi_p1", hi[0][c], 0);

    // Basic duty 40_80_FF
    load_one(24'h4080FF);
    chk("basic_pending_after_load", int'(pend[0]), 1);
    goto_wrap1();
    chk("basic_pending_at_wrap", int'(pend[0]), 1);
    step();
    chk("basic_pending_after_wrap", int'(pend[0]), 0);
    chk("basic_frame_start", int'(fs[0]), 1);
    measure(256);
    chk("basic_hi_r", hi[0][0], 64);
    chk("basic_hi_g", hi[0][1], 128);
    chk("basic_hi_b", hi[0][2], 256);
    chk("basic_fs_per_period", fsn[0], 1);

    // Converter colour sweep
    for (int i = 0; i < 8; i++) begin
      logic [23:0] col;
      col = sweep[i];
      load_one(col);
      goto_wrap1();
      step();
      measure(256);
      for (int c = 0; c < 3; c++)
        chk("sweep_hi", hi[0][c], (col[8*(2-c) +: 8] != 8'h00) ? 256 : 0);
    end

    // Load exactly on the wrap cycle (bypass)
    goto_wrap1();
    load_one(24'h101010);
    chk("bypass_pending", int'(pend[0]), 0);
    measure(256);
    for (int c = 0; c < 3; c++) chk("bypass_hi", hi[0][c], 16);

    // Load one cycle after wrap waits a full period
    load_one(24'h202020);
    chk("late_pending", int'(pend[0]), 1);
    goto_wrap1();
    chk("late_pending_at_wrap", int'(pend[0]), 1);
    step();
    measure(256);
    for (int c = 0; c < 3; c++) chk("late_hi", hi[0][c], 32);

    // Overwrite: last load before wrap wins
    load_one(24'h111111);
    repeat (20) step();
    load_one(24'h222222);
    repeat (20) step();
    load_one(24'h333333);
    goto_wrap1();
    step();
    measure(256);
    for (int c = 0; c < 3; c++) chk("overwrite_hi", hi[0][c], 51);

    // PRESCALE=4 with duty 02
    load_one(24'h020202);
    goto_wrap4();
    step();
    chk("p4_frame_start", int'(fs[1]), 1);
    measure(1024);
    for (int c = 0; c < 3; c++) chk("p4_hi", hi[1][c], 8);
    chk("p4_fs_per_period", fsn[1], 1);

    // Reset while a colour is pending discards it
    load_one(24'h555555);
    chk("pend_before_reset_p4", int'(pend[1]), 1);
    do_reset();
    chk("pend_after_reset_p4", int'(pend[1]), 0);
    measure(1100);
    for (int c = 0; c < 3; c++) begin
      chk("lost_hi_p1", hi[0][c], 0);
      chk("lost_hi_p4", hi[1][c], 0);
    end

    // Randomised loads, including held strobes
    for (int i = 0; i < 3000; i++) begin
      rgb  = 24'($urandom);
      load = ($urandom_range(0, 7) == 0);
      step();
    end
    load = 1'b0;
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Downstream stage of the RGB colour converter. Takes the 24-bit `rgb` word (R in [23:16], G in [15:8], B in [7:0]) and drives three PWM outputs, one per channel, for an RGB LED. New colours are staged on a `load` strobe and applied only at a PWM period boundary, so the LED never shows a torn or glitched period.

## Interface
- `PRESCALE`, default 4: clocks per PWM tick; legal range ≥1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rgb` in 24: colour word from the converter.
- `load` in 1: one-clock strobe; samples `rgb` into the staging register.
- `pending` out 1: staged colour is waiting for the next period boundary.
- `frame_start` out 1: one-clock pulse in the cycle the period counter is 0 after a wrap.
- `pwm_r`, `pwm_g`, `pwm_b` out 1 each: registered PWM outputs.

## Operation
- Prescaler `pre` counts 0..PRESCALE-1. `tick` = (`pre` == PRESCALE-1). With PRESCALE=1, `tick` is always 1.
- 8-bit period counter `cnt` increments on `tick` and wraps from 255 to 0. `wrap` = `tick` & (`cnt` == 255).
- Staging: when `load`=1, `staged` <= `rgb` and `pending` <= 1.
- Shadow (active duty): when `wrap`=1 and (`pending` or `load`), `duty` takes the staged value and `pending` <= 0.
  - If `load` and `wrap` fall in the same cycle, `duty` <= `rgb` directly (bypass), `staged` <= `rgb`, and `pending` ends at 0.
  - If `load` and `wrap` are not simultaneous, only the latest `load` before `wrap` is applied. Earlier loads are overwritten.
- Per channel: `pwm_x` <= (`cnt` < `duty_x`) | (`duty_x` == 8'hFF).
  - Duty 0x00 gives a constant low output.
  - Duty 0xFF gives a constant high output (full on).
  - Otherwise the output is high for `duty_x` ticks out of every 256.
- `frame_start` <= `wrap`.
- Arithmetic:
  - All compares are unsigned 8-bit.
  - `cnt` and `pre` wrap modulo their range and never saturate.
  - The `pre` width is clog2(PRESCALE), with a minimum of 1.

## Timing
- Reset (async assert, sync-safe deassert): `pre`=0, `cnt`=0, `staged`=0, `duty`=0, `pending`=0, `frame_start`=0, all `pwm_x`=0.
- PWM period is 256×PRESCALE clocks.
- `pwm_x` lags `cnt` by 1 clock.
- Load-to-output latency:
  - `duty` changes on the clock edge that ends the `wrap` cycle.
  - `pwm_x` reflects the new duty on the following edge, which is also the edge that raises `frame_start`.
  - Worst case from `load` to visible change is 256×PRESCALE+1 clocks.
- `pending` rises on the edge after `load` and falls on the edge ending the `wrap` cycle.
- Reset asserted mid-period: all state clears immediately and any staged colour is discarded. The first period after reset starts at `cnt`=0 with duty 0.
- `load` held high for several clocks: each clock re-samples `rgb`. This is legal and the last sample wins.

## Structure
- Shared package `rgb_pwm_pkg` holds:
  - `CH_W`=8 and `RGB_W`=24.
  - Channel slice constants `R_HI/R_LO`, `G_HI/G_LO`, `B_HI/B_LO`.
  - The typedef `duty_t` (logic [7:0]).
- Sub-module `pwm_channel` (inputs `clk`, `rst_n`, `cnt`, `duty`; output `pwm`) holds the compare and output register. It is instantiated three times.
- The prescaler, period counter, staging, shadow and `frame_start` logic live in the top module.

## Test plan
Run with PRESCALE=1 unless noted.
1. Reset then idle:
   - Stimulus: assert `rst_n`=0 mid-run, then release.
   - Required: all outputs 0, `pending`=0, `frame_start` pulses every 256 clocks, every `pwm_x` stays 0.
2. Basic duty:
   - Stimulus: `load` with `rgb`=24'h40_80_FF.
   - Required: next period has `pwm_r` high 64 clocks, `pwm_g` high 128 clocks, `pwm_b` high all 256. `pending` is 1 until the wrap.
3. Colour sweep matching the converter:
   - Stimulus: load each of 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF, one per period.
   - Required: each channel is constant 0 or constant 1 for the whole period, matching its byte.
4. Boundary race:
   - Stimulus: `load` 24'h10_10_10 in the exact `wrap` cycle.
   - Required: applied in the immediately following period (bypass) and `pending`=0 afterwards.
   - Stimulus: `load` 24'h20_20_20 one cycle after `wrap`.
   - Required: waits a full period before being applied.
5. Overwrite:
   - Stimulus: three loads (11, 22, 33 in all channels) inside one period.
   - Required: only 24'h33_33_33 appears, with high time 51 clocks.
6. Prescale and reset mid-operation:
   - Stimulus: PRESCALE=4 with duty 8'h02.
   - Required: period is 1024 clocks, high time 8 clocks.
   - Stimulus: assert reset while `pending`=1.
   - Required: staged colour is lost and outputs stay 0.
